// File: rtl/div_result_bcd_if.sv
// Handshake and result bus between a requester and the divider-result BCD converter.
// Latency: none, this file only groups wires.
// Backpressure: none; the requester watches busy, and starts issued while busy are dropped.
// Optional 7-segment outputs are present only when DIV_RESULT_BCD_SEG_EN is defined.
interface div_result_bcd_if;
    logic       start;
    logic [8:0] result_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] q_tens;
    logic [3:0] q_ones;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
`ifdef DIV_RESULT_BCD_SEG_EN
    logic [6:0] seg_q1;
    logic [6:0] seg_q0;
    logic [6:0] seg_r1;
    logic [6:0] seg_r0;
`endif

    modport master (
        output start,
        output result_in,
        input  busy,
        input  done,
        input  err,
        input  q_tens,
        input  q_ones,
        input  r_tens,
        input  r_ones
`ifdef DIV_RESULT_BCD_SEG_EN
        ,
        input  seg_q1,
        input  seg_q0,
        input  seg_r1,
        input  seg_r0
`endif
    );

    modport slave (
        input  start,
        input  result_in,
        output busy,
        output done,
        output err,
        output q_tens,
        output q_ones,
        output r_tens,
        output r_ones
`ifdef DIV_RESULT_BCD_SEG_EN
        ,
        output seg_q1,
        output seg_q0,
        output seg_r1,
        output seg_r0
`endif
    );
endinterface

// File: rtl/div_result_bcd.sv
// Converts a 4-bit quotient and 4-bit remainder to BCD digits, one double-dabble step per cycle.
// Latency: done pulses 8 cycles after the accepting edge; the next start is accepted in the done cycle.
// Backpressure: start is ignored while busy is high, with no queuing. Optional macro: DIV_RESULT_BCD_SEG_EN.
module div_result_bcd (
    input  logic              clk,
    input  logic              resetn,
    div_result_bcd_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    // [15:8] is the BCD accumulator, [7:0] holds the binary bits that have not been shifted in yet.
    logic [15:0] sr_q, sr_d;
    logic        perr_q, perr_d;
    logic [7:0]  qbcd_q, qbcd_d;
    logic [15:0] dig_q, dig_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [15:0] step;

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left by one bit.
    function automatic logic [15:0] dabble(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[14:0], 1'b0};
    endfunction

    assign step = dabble(sr_q);

    // Next-state logic: accept a start in IDLE, run four quotient steps, then four remainder steps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        perr_d  = perr_q;
        qbcd_d  = qbcd_q;
        dig_d   = dig_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // The quotient goes in the upper binary nibble so that it is shifted in first.
                    sr_d    = {8'h00, bus.result_in[3:0], bus.result_in[7:4]};
                    perr_d  = bus.result_in[8];
                    cnt_d   = 2'd0;
                    state_d = CONV_Q;
                end
            end
            CONV_Q: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    // Save the quotient digits and clear the accumulator for the remainder.
                    qbcd_d  = step[15:8];
                    sr_d    = {8'h00, step[7:0]};
                    state_d = CONV_R;
                end else begin
                    sr_d = step;
                end
            end
            CONV_R: begin
                cnt_d = cnt_q + 2'd1;
                sr_d  = step;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (perr_q) begin
                        dig_d = 16'h0000;
                        err_d = 1'b1;
                    end else begin
                        dig_d = {qbcd_q, step[15:8]};
                        err_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; a reset mid-conversion drops it without a done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            sr_q    <= 16'h0000;
            perr_q  <= 1'b0;
            qbcd_q  <= 8'h00;
            dig_q   <= 16'h0000;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            perr_q  <= perr_d;
            qbcd_q  <= qbcd_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.q_tens = dig_q[15:12];
    assign bus.q_ones = dig_q[11:8];
    assign bus.r_tens = dig_q[7:4];
    assign bus.r_ones = dig_q[3:0];

`ifdef DIV_RESULT_BCD_SEG_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Display decode from the registered digits: leading tens zero is blanked, err shows dashes.
    always_comb begin
        bus.seg_q1 = (dig_q[15:12] == 4'd0) ? SEG_BLANK : seg7(dig_q[15:12]);
        bus.seg_q0 = seg7(dig_q[11:8]);
        bus.seg_r1 = (dig_q[7:4] == 4'd0) ? SEG_BLANK : seg7(dig_q[7:4]);
        bus.seg_r0 = seg7(dig_q[3:0]);
        if (err_q) begin
            bus.seg_q1 = SEG_DASH;
            bus.seg_q0 = SEG_DASH;
            bus.seg_r1 = SEG_DASH;
            bus.seg_r0 = SEG_DASH;
        end
    end
`endif
endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: directed table, random results against a decimal model, and handshake corners.
// Latency: expects done exactly 8 cycles after the accepting edge, with busy high for 8 cycles.
// Backpressure: checks that a start while busy is dropped and that a start in the done cycle is taken.
module tb_div_result_bcd;
    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;

    div_result_bcd_if bus ();

    div_result_bcd dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] res;
        logic [3:0] qt, qo, rt, ro;
        logic       e;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: split the fields and take decimal tens and ones with plain division.
    function automatic vec_t model(input logic [8:0] v);
        vec_t m;
        int q, r;
        q = int'(v[3:0]);
        r = int'(v[7:4]);
        m.res = v;
        m.e   = v[8];
        m.qt  = v[8] ? 4'd0 : 4'(q / 10);
        m.qo  = v[8] ? 4'd0 : 4'(q % 10);
        m.rt  = v[8] ? 4'd0 : 4'(r / 10);
        m.ro  = v[8] ? 4'd0 : 4'(r % 10);
        return m;
    endfunction

`ifdef DIV_RESULT_BCD_SEG_EN
    function automatic logic [6:0] seg_exp(input logic [3:0] d, input logic tens, input logic e);
        logic [6:0] pat[10];
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
        if (e) return 7'b0111111;
        if (tens && d == 4'd0) return 7'b1111111;
        return pat[d];
    endfunction
`endif

    task automatic chk_out(input string tag, input vec_t m);
        chk({tag, ".err"},    16'(bus.err),    16'(m.e));
        chk({tag, ".q_tens"}, 16'(bus.q_tens), 16'(m.qt));
        chk({tag, ".q_ones"}, 16'(bus.q_ones), 16'(m.qo));
        chk({tag, ".r_tens"}, 16'(bus.r_tens), 16'(m.rt));
        chk({tag, ".r_ones"}, 16'(bus.r_ones), 16'(m.ro));
`ifdef DIV_RESULT_BCD_SEG_EN
        chk({tag, ".seg_q1"}, 16'(bus.seg_q1), 16'(seg_exp(m.qt, 1'b1, m.e)));
        chk({tag, ".seg_q0"}, 16'(bus.seg_q0), 16'(seg_exp(m.qo, 1'b0, m.e)));
        chk({tag, ".seg_r1"}, 16'(bus.seg_r1), 16'(seg_exp(m.rt, 1'b1, m.e)));
        chk({tag, ".seg_r0"}, 16'(bus.seg_r0), 16'(seg_exp(m.ro, 1'b0, m.e)));
`endif
    endtask

    // Waits for done after the accepting edge; reports cycles to done and busy cycles seen.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = int'(bus.busy);
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
            if (!bus.done) bc += int'(bus.busy);
        end
        if (!bus.done) chk("done_timeout", 16'(bus.done), 16'd1);
    endtask

    task automatic run(input string tag, input logic [8:0] v, input vec_t m);
        int lat, bc;
        bus.start     = 1'b1;
        bus.result_in = v;
        tick();
        bus.start     = 1'b0;
        bus.result_in = 9'($urandom);
        wait_done(lat, bc);
        chk({tag, ".latency"}, 16'(lat), 16'd8);
        chk({tag, ".busy_cycles"}, 16'(bc), 16'd8);
        chk_out(tag, m);
        tick();
        chk({tag, ".done_clear"}, 16'(bus.done), 16'd0);
    endtask

    initial begin
        int lat, bc, dones;
        vec_t m;
        logic [8:0] rv;
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{res: 9'h02D, qt: 4'd1, qo: 4'd3, rt: 4'd0, ro: 4'd2, e: 1'b0};
        tbl[1] = '{res: 9'h0FF, qt: 4'd1, qo: 4'd5, rt: 4'd1, ro: 4'd5, e: 1'b0};
        tbl[2] = '{res: 9'h000, qt: 4'd0, qo: 4'd0, rt: 4'd0, ro: 4'd0, e: 1'b0};
        tbl[3] = '{res: 9'h1A5, qt: 4'd0, qo: 4'd0, rt: 4'd0, ro: 4'd0, e: 1'b1};
        tbl[4] = '{res: 9'h039, qt: 4'd0, qo: 4'd9, rt: 4'd0, ro: 4'd3, e: 1'b0};
        tbl[5] = '{res: 9'h07A, qt: 4'd1, qo: 4'd0, rt: 4'd0, ro: 4'd7, e: 1'b0};

        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.result_in = 9'h000;
        tick();
        tick();
        chk("reset.busy", 16'(bus.busy), 16'd0);
        chk("reset.done", 16'(bus.done), 16'd0);
        chk_out("reset", tbl[2]);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run($sformatf("tbl%0d", i), tbl[i].res, tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv = 9'($urandom);
            run($sformatf("rnd%0d", i), rv, model(rv));
        end

        // A start while busy must be dropped; exactly one done with the first result.
        bus.start = 1'b1; bus.result_in = 9'h02D;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.start = 1'b1; bus.result_in = 9'h0FF;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done) dones++;
            tick();
        end
        chk("busy_start.dones", 16'(dones), 16'd1);
        chk_out("busy_start", tbl[0]);

        // A start presented in the done cycle is accepted at once.
        bus.start = 1'b1; bus.result_in = 9'h039;
        tick();
        bus.start = 1'b0;
        wait_done(lat, bc);
        bus.start = 1'b1; bus.result_in = 9'h0FF;
        tick();
        bus.start = 1'b0;
        chk("done_start.busy", 16'(bus.busy), 16'd1);
        wait_done(lat, bc);
        chk("done_start.latency", 16'(lat), 16'd8);
        chk_out("done_start", tbl[1]);
        tick();

        // Reset mid-conversion aborts with no done, then a fresh start converts normally.
        bus.start = 1'b1; bus.result_in = 9'h0FF;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            tick();
        end
        chk("abort.dones", 16'(dones), 16'd0);
        chk("abort.busy", 16'(bus.busy), 16'd0);
        chk_out("abort", tbl[2]);
        run("after_abort", 9'h07A, tbl[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
